data_mem_responder: RTL and testbench

Responder end of the processor's data-memory port: accepts the read and write requests the pipeline issues on `DataAddr`/`ReadData`/`WriteData`/`DataOut`, and answers on `DataIn`/`DataDone`. It inserts a configurable number of wait states so that the processor's Memory1 stall path is exercised. It sits beside the processor in the top level, wired port-for-port by name, and is also the data-memory model used in the processor bench.

---
 rtl/proc_pkg.sv | 25 ++
 rtl/data_mem_responder_data_ram.sv | 40 ++++
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 tb/tb_data_mem_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: word width, pipeline latch/control types
// and small elaboration-time helpers used by the processor and its memories.
package proc_pkg;

    localparam int WORD_SIZE = 16;

    // Memory request kind as issued by the pipeline.
    typedef struct packed {
        logic read;
        logic write;
    } control_signals;

    // Values latched between pipeline stages for a memory access.
    typedef struct packed {
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
        control_signals       ctrl;
    } latched_values;

    // Width of a down-counter that must hold the value n; never narrower than 1.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_data_ram.sv
// Single-port synchronous RAM with a registered, enable-gated read port.
// The read register holds its value when not enabled so it can drive the
// processor's read-data bus directly.
module data_ram #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 re,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_SIZE-1:0] mem [0:DEPTH-1];
    logic [WORD_SIZE-1:0] rdata_q;

    // Storage array: write port only, contents survive reset.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; cleared by reset, otherwise updated only on a read.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts processor read/write requests, stalls the
// pipeline for WAIT_STATES cycles, performs the access and flags protocol
// violations in a sticky error bit.
module data_mem_responder
    import proc_pkg::*;
#(
    parameter int WORD_SIZE   = proc_pkg::WORD_SIZE,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 ProtoErr
);

    localparam int CNT_W = cnt_width(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 is_wr_q, is_wr_d;
    logic                 perr_q, perr_d;

    control_signals       req;
    logic                 req_valid;
    logic [ADDR_BITS-1:0] req_addr;

    logic                 ram_re;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [WORD_SIZE-1:0] ram_wdata;
    logic [WORD_SIZE-1:0] ram_rdata;

    assign req.read  = ReadData;
    assign req.write = WriteData;
    assign req_valid = req.read | req.write;
    assign req_addr  = DataAddr[ADDR_BITS-1:0];

    // Address bits above the RAM index alias onto the same words.
    generate
        if (ADDR_BITS < WORD_SIZE) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^DataAddr[WORD_SIZE-1:ADDR_BITS];
        end
    endgenerate

    // Next-state, capture, protocol-check and RAM-port decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        perr_d    = perr_q;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = DataOut;
                    // A request flagged as both read and write is served as a write.
                    is_wr_d = req.write;
                    if (req.read && req.write) begin
                        perr_d = 1'b1;
                    end
                    if (WAIT_STATES == 0) begin
                        ram_addr  = req_addr;
                        ram_wdata = DataOut;
                        ram_we    = req.write;
                        ram_re    = ~req.write;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_STATES);
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // The processor must hold an identical request while stalled.
                if (!req_valid || (req_addr != addr_q) || (req.write != is_wr_q) ||
                    (is_wr_q && (DataOut != wdata_q))) begin
                    perr_d = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    ram_we  = is_wr_q;
                    ram_re  = ~is_wr_q;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, captured request and sticky error registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            perr_q  <= perr_d;
        end
    end

    // No write may land while reset is held, even for a request on the bus.
    data_ram #(
        .WORD_SIZE(WORD_SIZE),
        .ADDR_BITS(ADDR_BITS)
    ) u_data_ram (
        .Clock(Clock),
        .Reset(Reset),
        .re   (ram_re & ~Reset),
        .we   (ram_we & ~Reset),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign DataIn   = ram_rdata;
    assign DataDone = (state_q != S_WAIT);
    assign ProtoErr = perr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances with 0, 1 and 2 wait states,
// each checked against a transaction-level model of memory, read data and
// the sticky protocol-error flag.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_s  [3];
    logic [15:0] addr_s [3];
    logic [15:0] dout_s [3];
    logic        rd_s   [3];
    logic        wr_s   [3];
    logic [15:0] din_s  [3];
    logic        done_s [3];
    logic        perr_s [3];

    // Reference model, indexed by instance (= its wait-state count).
    logic [15:0] mem_m  [3][256];
    bit          val_m  [3][256];
    logic [15:0] din_m  [3];
    bit          perr_m [3];

    int tests_run;
    int tests_failed;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            data_mem_responder #(
                .WORD_SIZE  (16),
                .ADDR_BITS  (8),
                .WAIT_STATES(gi)
            ) u_dut (
                .Clock    (clk),
                .Reset    (rst_s[gi]),
                .DataAddr (addr_s[gi]),
                .DataOut  (dout_s[gi]),
                .ReadData (rd_s[gi]),
                .WriteData(wr_s[gi]),
                .DataIn   (din_s[gi]),
                .DataDone (done_s[gi]),
                .ProtoErr (perr_s[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access on instance k, starting at a negedge with the DUT ready.
    // The request is held for the whole stall and released at the end, so a
    // following call in the same time step is a back-to-back request.
    task automatic do_access(input int k, input bit rd, input bit wr,
                             input logic [15:0] a, input logic [15:0] d, input string tag);
        tests_run++;
        if (done_s[k] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ready inst%0d: DataDone=%b expected 1", tag, k, done_s[k]);
        end
        addr_s[k] = a; dout_s[k] = d; rd_s[k] = rd; wr_s[k] = wr;
        if (rd && wr) perr_m[k] = 1'b1;
        if (wr) begin
            mem_m[k][a[7:0]] = d;
            val_m[k][a[7:0]] = 1'b1;
        end else begin
            din_m[k] = mem_m[k][a[7:0]];
        end
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            tests_run++;
            if (done_s[k] !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_stall%0d inst%0d: DataDone=%b expected 0", tag, i, k, done_s[k]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (done_s[k] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_done inst%0d: DataDone=%b expected 1", tag, k, done_s[k]);
        end
        tests_run++;
        if (din_s[k] !== din_m[k]) begin
            tests_failed++;
            $display("FAIL %s_data inst%0d addr=%h: DataIn=%h expected %h", tag, k, a, din_s[k], din_m[k]);
        end
        tests_run++;
        if (perr_s[k] !== perr_m[k]) begin
            tests_failed++;
            $display("FAIL %s_perr inst%0d: ProtoErr=%b expected %b", tag, k, perr_s[k], perr_m[k]);
        end
        $display("[TB] inst%0d %s rd=%0b wr=%0b addr=%h wdata=%h -> DataIn=%h ProtoErr=%b",
                 k, tag, rd, wr, a, d, din_s[k], perr_s[k]);
        rd_s[k] = 1'b0; wr_s[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (done_s[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_done inst%0d: DataDone=%b expected 1", k, done_s[k]);
            end
            tests_run++;
            if (din_s[k] !== 16'h0000) begin
                tests_failed++;
                $display("FAIL reset_din inst%0d: DataIn=%h expected 0000", k, din_s[k]);
            end
            tests_run++;
            if (perr_s[k] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_perr inst%0d: ProtoErr=%b expected 0", k, perr_s[k]);
            end
            $display("[TB] inst%0d reset: DataDone=%b DataIn=%h ProtoErr=%b", k, done_s[k], din_s[k], perr_s[k]);
        end
    endtask

    // Zero wait states: write then read the same word in the very next cycle.
    task automatic test_w0_write_read();
        do_access(0, 1'b0, 1'b1, 16'h0010, 16'h1234, "w0_write");
        do_access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, "w0_read");
        @(negedge clk);
    endtask

    // Two wait states: preload then read with the request held through the stall.
    task automatic test_w2_read_stall();
        do_access(2, 1'b0, 1'b1, 16'h0003, 16'hBEEF, "w2_preload");
        @(negedge clk);
        do_access(2, 1'b1, 1'b0, 16'h0003, 16'h0000, "w2_read");
        @(negedge clk);
    endtask

    // Reset in the second stall cycle of a write aborts that write.
    task automatic test_reset_mid_wait();
        do_access(2, 1'b0, 1'b1, 16'h0007, 16'h1111, "rst_preload");
        @(negedge clk);
        addr_s[2] = 16'h0007; dout_s[2] = 16'h5555; rd_s[2] = 1'b0; wr_s[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (done_s[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_prewait: DataDone=%b expected 0", done_s[2]);
        end
        rst_s[2] = 1'b1;
        #1;
        tests_run++;
        if (done_s[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_done: DataDone=%b expected 1", done_s[2]);
        end
        tests_run++;
        if (din_s[2] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_mid_din: DataIn=%h expected 0000", din_s[2]);
        end
        tests_run++;
        if (perr_s[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_perr: ProtoErr=%b expected 0", perr_s[2]);
        end
        $display("[TB] inst2 reset mid-wait: DataDone=%b DataIn=%h ProtoErr=%b", done_s[2], din_s[2], perr_s[2]);
        din_m[2] = 16'h0000;
        perr_m[2] = 1'b0;
        @(negedge clk);
        rst_s[2] = 1'b0; wr_s[2] = 1'b0;
        @(negedge clk);
        do_access(2, 1'b1, 1'b0, 16'h0007, 16'h0000, "rst_readback");
        @(negedge clk);
    endtask

    // Address bits above the index are ignored.
    task automatic test_aliasing();
        do_access(2, 1'b0, 1'b1, 16'h0105, 16'hAAAA, "alias_write");
        do_access(2, 1'b1, 1'b0, 16'h0005, 16'h0000, "alias_read");
        @(negedge clk);
    endtask

    // Random mix of reads/writes, gaps and back-to-back requests on every instance.
    task automatic test_random();
        logic [15:0] a;
        logic [15:0] d;
        int          low;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 40; n++) begin
                low = $urandom_range(0, 15);
                a = (16'($urandom_range(0, 255)) << 8) | 16'(low);
                d = 16'($urandom_range(0, 65535));
                if (!val_m[k][low] || ($urandom_range(0, 1) == 1))
                    do_access(k, 1'b0, 1'b1, a, d, "rand_write");
                else
                    do_access(k, 1'b1, 1'b0, a, d, "rand_read");
                if ($urandom_range(0, 2) == 0) @(negedge clk);
            end
            @(negedge clk);
        end
    endtask

    // One wait state: the address moves during the stall; captured address wins.
    task automatic test_proto_addr_change();
        do_access(1, 1'b0, 1'b1, 16'h0002, 16'h2222, "pc_pre2");
        do_access(1, 1'b0, 1'b1, 16'h0004, 16'h4444, "pc_pre4");
        @(negedge clk);
        addr_s[1] = 16'h0002; rd_s[1] = 1'b1; wr_s[1] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (done_s[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL pc_stall: DataDone=%b expected 0", done_s[1]);
        end
        addr_s[1] = 16'h0004;
        @(negedge clk);
        din_m[1] = mem_m[1][8'h02];
        perr_m[1] = 1'b1;
        tests_run++;
        if (din_s[1] !== din_m[1]) begin
            tests_failed++;
            $display("FAIL pc_data: DataIn=%h expected %h", din_s[1], din_m[1]);
        end
        tests_run++;
        if (perr_s[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pc_perr: ProtoErr=%b expected 1", perr_s[1]);
        end
        $display("[TB] inst1 addr change in wait: DataIn=%h ProtoErr=%b", din_s[1], perr_s[1]);
        rd_s[1] = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (perr_s[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pc_perr_sticky: ProtoErr=%b expected 1", perr_s[1]);
        end
        $display("[TB] inst1 idle after violation: ProtoErr=%b", perr_s[1]);
    endtask

    // Read and write both asserted: served as a write and flagged.
    task automatic test_both_high();
        do_access(2, 1'b1, 1'b1, 16'h0009, 16'h0F0F, "both_high");
        @(negedge clk);
        do_access(2, 1'b1, 1'b0, 16'h0009, 16'h0000, "both_readback");
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1; addr_s[k] = '0; dout_s[k] = '0; rd_s[k] = 1'b0; wr_s[k] = 1'b0;
            din_m[k] = '0; perr_m[k] = 1'b0;
            for (int j = 0; j < 256; j++) begin
                mem_m[k][j] = '0;
                val_m[k][j] = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        @(negedge clk);
        test_reset();
        test_w0_write_read();
        test_w2_read_stall();
        test_reset_mid_wait();
        test_aliasing();
        test_random();
        test_proto_addr_change();
        test_both_high();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
